// File: rtl/online_add_seq.sv
// Digit-serial MSD-first sequencer for a borrow-save adder digit cell.
// One combinational cell is shared: phase A forms the transfer of digit k, phase B finishes digit k-1.
module online_add_seq #(
    parameter int unsigned NDIG = 8,
    parameter int unsigned CW   = $clog2(NDIG + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] x_dig,
    input  logic [1:0] y_dig,
    output logic       z_valid,
    output logic       zp,
    output logic       zn,
    output logic       z_first,
    output logic       z_last,
    output logic       h_msd,
    output logic       busy,
    output logic       done,
    output logic [1:0] cell_x,
    output logic [1:0] cell_y,
    output logic       cell_hin,
    input  logic       cell_hout,
    input  logic       cell_zp,
    input  logic       cell_zn
);
    localparam int unsigned DW = 2;

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_EMIT, S_TAIL} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*DW-1:0] prev_q, prev_d;
    logic [2*DW-1:0] hold_q, hold_d;
    logic            h_reg_q, h_reg_d;
    logic            h_msd_q, h_msd_d;
    logic            z_valid_q, z_valid_d;
    logic            zp_q, zp_d;
    logic            zn_q, zn_d;
    logic            z_first_q, z_first_d;
    logic            z_last_q, z_last_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            in_ready_q, in_ready_d;

    // Next-state, datapath and cell-port steering
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prev_d    = prev_q;
        hold_d    = hold_q;
        h_reg_d   = h_reg_q;
        h_msd_d   = h_msd_q;
        zp_d      = zp_q;
        zn_d      = zn_q;
        z_first_d = z_first_q;
        z_last_d  = z_last_q;
        z_valid_d = 1'b0;
        done_d    = 1'b0;
        cell_x    = 2'b00;
        cell_y    = 2'b00;
        cell_hin  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // done_q marks the cycle right after TAIL; a start there is not a new request
                if (start && !done_q) begin
                    state_d = S_ACC;
                    cnt_d   = '0;
                end
            end
            S_ACC: begin
                cell_x = x_dig;
                cell_y = y_dig;
                if (in_valid) begin
                    if (cnt_q == '0) begin
                        prev_d  = {x_dig, y_dig};
                        h_msd_d = cell_hout;
                        cnt_d   = CW'(1);
                    end else begin
                        h_reg_d = cell_hout;
                        hold_d  = {x_dig, y_dig};
                        cnt_d   = CW'(cnt_q + CW'(1));
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                cell_x    = prev_q[3:2];
                cell_y    = prev_q[1:0];
                cell_hin  = h_reg_q;
                z_valid_d = 1'b1;
                zp_d      = cell_zp;
                zn_d      = cell_zn;
                z_first_d = (cnt_q == CW'(2));
                z_last_d  = 1'b0;
                prev_d    = hold_q;
                state_d   = (cnt_q == CW'(NDIG)) ? S_TAIL : S_ACC;
            end
            S_TAIL: begin
                cell_x    = prev_q[3:2];
                cell_y    = prev_q[1:0];
                z_valid_d = 1'b1;
                zp_d      = cell_zp;
                zn_d      = cell_zn;
                z_first_d = 1'b0;
                z_last_d  = 1'b1;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d != S_IDLE);
        in_ready_d = (state_d == S_ACC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            prev_q     <= '0;
            hold_q     <= '0;
            h_reg_q    <= 1'b0;
            h_msd_q    <= 1'b0;
            z_valid_q  <= 1'b0;
            zp_q       <= 1'b0;
            zn_q       <= 1'b0;
            z_first_q  <= 1'b0;
            z_last_q   <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prev_q     <= prev_d;
            hold_q     <= hold_d;
            h_reg_q    <= h_reg_d;
            h_msd_q    <= h_msd_d;
            z_valid_q  <= z_valid_d;
            zp_q       <= zp_d;
            zn_q       <= zn_d;
            z_first_q  <= z_first_d;
            z_last_q   <= z_last_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;
    assign z_valid  = z_valid_q;
    assign zp       = zp_q;
    assign zn       = zn_q;
    assign z_first  = z_first_q;
    assign z_last   = z_last_q;
    assign h_msd    = h_msd_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_online_add_seq.sv
// Bench for online_add_seq: NDIG=3 and NDIG=8 instances, each wired to a golden digit cell.
`timescale 1ns/1ps
module tb_online_add_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       start_s [2];
    logic       in_valid_s [2];
    logic [1:0] x_s [2];
    logic [1:0] y_s [2];
    logic       in_ready_s [2];
    logic       z_valid_s [2];
    logic       zp_s [2];
    logic       zn_s [2];
    logic       z_first_s [2];
    logic       z_last_s [2];
    logic       h_msd_s [2];
    logic       busy_s [2];
    logic       done_s [2];
    logic [1:0] cx_s [2];
    logic [1:0] cy_s [2];
    logic       chin_s [2];
    logic [2:0] cres [2];

    function automatic logic maj(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Golden cell: returns {hout, zp, zn}
    function automatic logic [2:0] cell_f(input logic [1:0] x, input logic [1:0] y, input logic hin);
        logic ho, s1, p, n;
        ho = maj(x[1], ~x[0], y[1]);
        s1 = x[1] ^ ~x[0] ^ y[1];
        p  = s1 ^ ~y[0] ^ hin;
        n  = ~maj(s1, ~y[0], hin);
        return {ho, p, n};
    endfunction

    assign cres[0] = cell_f(cx_s[0], cy_s[0], chin_s[0]);
    assign cres[1] = cell_f(cx_s[1], cy_s[1], chin_s[1]);

    online_add_seq #(.NDIG(3)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .in_valid(in_valid_s[0]),
        .in_ready(in_ready_s[0]), .x_dig(x_s[0]), .y_dig(y_s[0]), .z_valid(z_valid_s[0]),
        .zp(zp_s[0]), .zn(zn_s[0]), .z_first(z_first_s[0]), .z_last(z_last_s[0]),
        .h_msd(h_msd_s[0]), .busy(busy_s[0]), .done(done_s[0]), .cell_x(cx_s[0]),
        .cell_y(cy_s[0]), .cell_hin(chin_s[0]), .cell_hout(cres[0][2]),
        .cell_zp(cres[0][1]), .cell_zn(cres[0][0])
    );

    online_add_seq #(.NDIG(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .in_valid(in_valid_s[1]),
        .in_ready(in_ready_s[1]), .x_dig(x_s[1]), .y_dig(y_s[1]), .z_valid(z_valid_s[1]),
        .zp(zp_s[1]), .zn(zn_s[1]), .z_first(z_first_s[1]), .z_last(z_last_s[1]),
        .h_msd(h_msd_s[1]), .busy(busy_s[1]), .done(done_s[1]), .cell_x(cx_s[1]),
        .cell_y(cy_s[1]), .cell_hin(chin_s[1]), .cell_hout(cres[1][2]),
        .cell_zp(cres[1][1]), .cell_zn(cres[1][0])
    );

    int n_chk = 0;
    int n_pass = 0;

    logic [1:0] dx [8];
    logic [1:0] dy [8];
    logic [1:0] ev_z [$];
    logic       ev_f [$];
    logic       ev_l [$];
    int         ev_c [$];
    int         acc_c [8];
    int         done_c, c0, rdy_drop, z_in_stall;
    logic       hmsd_obs;

    function automatic int nd(input int i);
        return (i == 0) ? 3 : 8;
    endfunction

    // Reference: digit j uses the transfer of digit j+1; the last digit sees no transfer
    function automatic logic [1:0] exp_z(input int j, input int n);
        logic [2:0] t;
        logic h;
        h = 1'b0;
        if (j + 1 < n) begin
            t = cell_f(dx[j+1], dy[j+1], 1'b0);
            h = t[2];
        end
        t = cell_f(dx[j], dy[j], h);
        return t[1:0];
    endfunction

    function automatic logic exp_h();
        logic [2:0] t;
        t = cell_f(dx[0], dy[0], 1'b0);
        return t[2];
    endfunction

    // Runs one operation on instance i, recording result pulses; returns at the done cycle's negedge
    task automatic run_op(input int i, input int stall_k, input int stall_len, input bit rnd);
        int n, k, sc;
        ev_z.delete(); ev_f.delete(); ev_l.delete(); ev_c.delete();
        done_c = -1; rdy_drop = 0; z_in_stall = 0;
        n = nd(i); k = 0; sc = 0;
        @(negedge clk);
        start_s[i] = 1'b1;
        in_valid_s[i] = 1'b0;
        c0 = cyc;
        for (int t = 0; t < 400 && done_c < 0; t++) begin
            @(posedge clk);
            @(negedge clk);
            start_s[i] = rnd && busy_s[i] && ($urandom_range(3) == 0);
            if (z_valid_s[i]) begin
                ev_z.push_back({zp_s[i], zn_s[i]});
                ev_f.push_back(z_first_s[i]);
                ev_l.push_back(z_last_s[i]);
                ev_c.push_back(cyc);
            end
            if (done_s[i]) begin
                done_c = cyc;
                hmsd_obs = h_msd_s[i];
            end
            x_s[i] = 2'($urandom);
            y_s[i] = 2'($urandom);
            in_valid_s[i] = 1'b0;
            if (k < n && done_c < 0) begin
                if (k == stall_k && sc < stall_len) begin
                    sc++;
                    if (!in_ready_s[i]) rdy_drop++;
                    if (z_valid_s[i]) z_in_stall++;
                end else if (!(rnd && $urandom_range(3) == 0)) begin
                    in_valid_s[i] = 1'b1;
                    x_s[i] = dx[k];
                    y_s[i] = dy[k];
                end
                if (in_valid_s[i] && in_ready_s[i]) begin
                    acc_c[k] = cyc;
                    k++;
                end
            end
        end
        in_valid_s[i] = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] o0, o1;
        @(negedge clk);
        o0 = {busy_s[0], in_ready_s[0], z_valid_s[0], zp_s[0], zn_s[0], z_first_s[0],
              z_last_s[0], h_msd_s[0], done_s[0], cx_s[0], cy_s[0], chin_s[0]};
        n_chk++;
        if (o0 !== 13'd0) $display("FAIL reset_outputs_dut0: got %b expected 0", o0);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        o1 = {busy_s[1], in_ready_s[1], z_valid_s[1], zp_s[1], zn_s[1], z_first_s[1],
              z_last_s[1], h_msd_s[1], done_s[1], cx_s[1], cy_s[1], chin_s[1]};
        n_chk++;
        if (o1 !== 13'd0) $display("FAIL idle_outputs_dut1: got %b expected 0", o1);
        else n_pass++;
    endtask

    task automatic test_directed(input logic [1:0] pat, input logic h_req, input string nm);
        int n, m, ec;
        n = nd(0);
        for (int j = 0; j < 8; j++) begin
            dx[j] = pat;
            dy[j] = pat;
        end
        run_op(0, -1, 0, 1'b0);
        n_chk++;
        if (done_c !== c0 + 2*n + 1) $display("FAIL %s_done_cycle: got c%0d expected c%0d", nm, done_c - c0, 2*n + 1);
        else n_pass++;
        n_chk++;
        if (ev_z.size() !== n) $display("FAIL %s_count: got %0d expected %0d", nm, ev_z.size(), n);
        else n_pass++;
        m = (ev_z.size() < n) ? ev_z.size() : n;
        for (int j = 0; j < m; j++) begin
            n_chk++;
            if (ev_z[j] !== exp_z(j, n)) $display("FAIL %s_z%0d: got %b expected %b", nm, j, ev_z[j], exp_z(j, n));
            else n_pass++;
            n_chk++;
            if ({ev_f[j], ev_l[j]} !== {j == 0, j == n - 1})
                $display("FAIL %s_flags%0d: got %b%b expected %b%b", nm, j, ev_f[j], ev_l[j], j == 0, j == n - 1);
            else n_pass++;
            ec = (j == n - 1) ? 2*n + 1 : 2*(j + 2);
            n_chk++;
            if (ev_c[j] - c0 !== ec) $display("FAIL %s_zcycle%0d: got c%0d expected c%0d", nm, j, ev_c[j] - c0, ec);
            else n_pass++;
        end
        n_chk++;
        if (hmsd_obs !== h_req) $display("FAIL %s_h_msd: got %b expected %b", nm, hmsd_obs, h_req);
        else n_pass++;
    endtask

    task automatic test_stall();
        for (int j = 0; j < 8; j++) begin
            dx[j] = 2'($urandom);
            dy[j] = 2'($urandom);
        end
        run_op(0, 1, 5, 1'b0);
        n_chk++;
        if (rdy_drop !== 0 || z_in_stall !== 0)
            $display("FAIL stall_quiet: got in_ready drops %0d z_valid %0d expected 0 0", rdy_drop, z_in_stall);
        else n_pass++;
        n_chk++;
        if (acc_c[1] - c0 !== 7) $display("FAIL stall_accept2: got c%0d expected c7", acc_c[1] - c0);
        else n_pass++;
        n_chk++;
        if (done_c - c0 !== 12) $display("FAIL stall_done_cycle: got c%0d expected c12", done_c - c0);
        else n_pass++;
        n_chk++;
        if (ev_z.size() !== 3 || ev_z[0] !== exp_z(0, 3) || ev_z[1] !== exp_z(1, 3) || ev_z[2] !== exp_z(2, 3))
            $display("FAIL stall_z: got %0d digits expected 3 matching model", ev_z.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int seen;
        logic [3:0] o;
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        in_valid_s[0] = 1'b1;
        x_s[0] = 2'b10;
        y_s[0] = 2'b10;
        @(negedge clk);
        @(negedge clk);
        in_valid_s[0] = 1'b0;
        @(negedge clk);
        o = {busy_s[0], z_valid_s[0], in_ready_s[0], h_msd_s[0]};
        n_chk++;
        if (o !== 4'b1111) $display("FAIL rstmid_pre: got %b expected 1111", o);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        o = {busy_s[0], z_valid_s[0], in_ready_s[0], h_msd_s[0]};
        n_chk++;
        if (o !== 4'b0000) $display("FAIL rstmid_immediate: got %b expected 0000", o);
        else n_pass++;
        seen = 0;
        for (int t = 0; t < 6; t++) begin
            if (t == 2) rst_n = 1'b1;
            @(negedge clk);
            if (z_valid_s[0] || done_s[0] || busy_s[0]) seen++;
        end
        n_chk++;
        if (seen !== 0) $display("FAIL rstmid_no_done: got %0d active cycles expected 0", seen);
        else n_pass++;
        for (int j = 0; j < 8; j++) begin
            dx[j] = 2'($urandom);
            dy[j] = 2'($urandom);
        end
        run_op(0, -1, 0, 1'b0);
        n_chk++;
        if (done_c < 0 || ev_z.size() !== 3 || ev_z[0] !== exp_z(0, 3) || ev_z[1] !== exp_z(1, 3) ||
            ev_z[2] !== exp_z(2, 3) || hmsd_obs !== exp_h())
            $display("FAIL rstmid_restart: got %0d digits done_c %0d expected 3 matching model", ev_z.size(), done_c);
        else n_pass++;
    endtask

    task automatic test_start_at_done();
        logic [1:0] lastz;
        int act;
        for (int j = 0; j < 8; j++) begin
            dx[j] = 2'($urandom);
            dy[j] = 2'($urandom);
        end
        run_op(0, -1, 0, 1'b0);
        lastz = exp_z(2, 3);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        act = 0;
        for (int t = 0; t < 4; t++) begin
            if (busy_s[0] || in_ready_s[0] || z_valid_s[0] || done_s[0]) act++;
            if ({zp_s[0], zn_s[0], z_first_s[0], z_last_s[0]} !== {lastz, 2'b01}) act++;
            @(negedge clk);
        end
        n_chk++;
        if (act !== 0) $display("FAIL start_at_done_ignored: got %0d deviating cycles expected 0", act);
        else n_pass++;
    endtask

    task automatic test_random_runs();
        logic [15:0] oz, ez;
        logic [7:0]  of, ol;
        int bad_cnt, bad_z, bad_fl, bad_h;
        bad_cnt = 0; bad_z = 0; bad_fl = 0; bad_h = 0;
        for (int r = 0; r < 1000; r++) begin
            for (int j = 0; j < 8; j++) begin
                dx[j] = 2'($urandom);
                dy[j] = 2'($urandom);
            end
            run_op(1, -1, 0, 1'b1);
            oz = '0; ez = '0; of = '0; ol = '0;
            for (int j = 0; j < 8; j++) begin
                ez[2*j +: 2] = exp_z(j, 8);
                if (j < ev_z.size()) begin
                    oz[2*j +: 2] = ev_z[j];
                    of[j] = ev_f[j];
                    ol[j] = ev_l[j];
                end
            end
            n_chk++;
            if (done_c < 0 || ev_z.size() !== 8) begin
                if (bad_cnt < 5) $display("FAIL rand_count run %0d: got %0d digits done_c %0d expected 8", r, ev_z.size(), done_c);
                bad_cnt++;
            end else n_pass++;
            n_chk++;
            if (oz !== ez) begin
                if (bad_z < 5) $display("FAIL rand_z run %0d: got %h expected %h", r, oz, ez);
                bad_z++;
            end else n_pass++;
            n_chk++;
            if ({of, ol} !== {8'h01, 8'h80}) begin
                if (bad_fl < 5) $display("FAIL rand_flags run %0d: got first %b last %b expected 00000001 10000000", r, of, ol);
                bad_fl++;
            end else n_pass++;
            n_chk++;
            if (hmsd_obs !== exp_h()) begin
                if (bad_h < 5) $display("FAIL rand_h_msd run %0d: got %b expected %b", r, hmsd_obs, exp_h());
                bad_h++;
            end else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            in_valid_s[i] = 1'b0;
            x_s[i] = 2'b00;
            y_s[i] = 2'b00;
        end
        test_reset();
        test_directed(2'b00, 1'b0, "zero");
        test_directed(2'b10, 1'b1, "pos");
        test_directed(2'b01, 1'b0, "neg");
        test_stall();
        test_reset_mid();
        test_start_at_done();
        test_random_runs();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
